// File: rtl/gl_vga_timing_gen.sv
// rtl/gl_vga_timing_gen.sv - parametrised VGA raster timing generator with 4-mode test pattern
// Optional macro GLVGA_BORDER_EN: forces a red one-pixel frame border over every pattern.
module gl_vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CE_DIV   = 2,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    output logic          ce_pix,
    output logic          HBlank,
    output logic          HSync,
    output logic          VBlank,
    output logic          VSync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic [7:0]    vr,
    output logic [7:0]    vg,
    output logic [7:0]    vb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_EDGE_C = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_EDGE_C = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_W_C  = CW'(BAR_W);
    localparam logic [CW-1:0] BAR_MAX  = CW'(7);
    localparam logic [3:0]    CDIV_MAX = 4'(CE_DIV - 1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic [3:0]    cdiv_q, cdiv_d;
    logic          ce_pix_q, ce_pix_d;
    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          hblank_q, hblank_d;
    logic          hsync_q, hsync_d;
    logic          vblank_q, vblank_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    vr_q, vr_d;
    logic [7:0]    vg_q, vg_d;
    logic [7:0]    vb_q, vb_d;

    logic          h_act, v_act, hs_act, vs_act;
    logic          at_origin, h_last, v_last;
    logic [1:0]    mode_eff;
    logic [CW-1:0] bar_full;
    logic [2:0]    bar;
    logic [23:0]   pat;

    // Decode of the current raster position; registered one ce later below.
    always_comb begin
        h_act     = (hc_q < H_ACT_C);
        v_act     = (vc_q < V_ACT_C);
        hs_act    = (hc_q >= HS_BEG_C) && (hc_q < HS_END_C);
        vs_act    = (vc_q >= VS_BEG_C) && (vc_q < VS_END_C);
        at_origin = (hc_q == '0) && (vc_q == '0);
        h_last    = (hc_q == H_LAST_C);
        v_last    = (vc_q == V_LAST_C);
        // The new mode must already apply to pixel (0,0) of the frame it is latched for.
        mode_eff  = at_origin ? mode : mode_q;
        bar_full  = hc_q / BAR_W_C;
        bar       = (bar_full > BAR_MAX) ? 3'd7 : bar_full[2:0];
        pat       = 24'h000000;
        case (mode_eff)
            2'd0: pat = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            2'd1: pat = ((hc_q[2:0] == 3'd0) || (vc_q[2:0] == 3'd0) ||
                         (hc_q == H_EDGE_C) || (vc_q == V_EDGE_C)) ? 24'hFFFFFF : 24'h000000;
            2'd2: pat = (hc_q[4] ^ vc_q[4]) ? 24'hFFFFFF : 24'h0000FF;
            default: pat = {hc_q[7:0], vc_q[7:0], fcnt_q};
        endcase
`ifdef GLVGA_BORDER_EN
        if ((hc_q == '0) || (hc_q == H_EDGE_C) || (vc_q == '0) || (vc_q == V_EDGE_C)) begin
            pat = 24'hFF0000;
        end
`endif
    end

    always_comb begin
        cdiv_d        = (cdiv_q == CDIV_MAX) ? 4'd0 : cdiv_q + 4'd1;
        ce_pix_d      = (cdiv_q == CDIV_MAX);
        hc_d          = hc_q;
        vc_d          = vc_q;
        fcnt_d        = fcnt_q;
        mode_d        = mode_q;
        hblank_d      = hblank_q;
        hsync_d       = hsync_q;
        vblank_d      = vblank_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = frame_start_q;
        vr_d          = vr_q;
        vg_d          = vg_q;
        vb_d          = vb_q;
        if (ce_pix_q) begin
            hc_d = h_last ? '0 : hc_q + 1'b1;
            if (h_last) begin
                vc_d = v_last ? '0 : vc_q + 1'b1;
            end
            if (h_last && v_last) begin
                fcnt_d = fcnt_q + 8'd1;
            end
            if (at_origin) begin
                mode_d = mode;
            end
            hblank_d      = ~h_act;
            vblank_d      = ~v_act;
            hsync_d       = hs_act ? HS_ON : ~HS_ON;
            vsync_d       = vs_act ? VS_ON : ~VS_ON;
            de_d          = h_act && v_act;
            x_d           = (h_act && v_act) ? hc_q : '0;
            y_d           = (h_act && v_act) ? vc_q : '0;
            frame_start_d = at_origin;
            {vr_d, vg_d, vb_d} = (h_act && v_act) ? pat : 24'h000000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdiv_q        <= 4'd0;
            ce_pix_q      <= 1'b0;
            hc_q          <= '0;
            vc_q          <= '0;
            fcnt_q        <= 8'd0;
            mode_q        <= 2'd0;
            hblank_q      <= 1'b1;
            hsync_q       <= ~HS_ON;
            vblank_q      <= 1'b1;
            vsync_q       <= ~VS_ON;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            vr_q          <= 8'd0;
            vg_q          <= 8'd0;
            vb_q          <= 8'd0;
        end else begin
            cdiv_q        <= cdiv_d;
            ce_pix_q      <= ce_pix_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            fcnt_q        <= fcnt_d;
            mode_q        <= mode_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            vr_q          <= vr_d;
            vg_q          <= vg_d;
            vb_q          <= vb_d;
        end
    end

    assign ce_pix      = ce_pix_q;
    assign HBlank      = hblank_q;
    assign HSync       = hsync_q;
    assign VBlank      = vblank_q;
    assign VSync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign vr          = vr_q;
    assign vg          = vg_q;
    assign vb          = vb_q;

endmodule

// File: tb/tb_gl_vga_timing_gen.sv
// tb/tb_gl_vga_timing_gen.sv - directed self-checking bench for gl_vga_timing_gen
module tb_gl_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b;
    logic [1:0]  mode_a, mode_b;
    logic        ce_pix_a, hblank_a, hsync_a, vblank_a, vsync_a, de_a, fs_a;
    logic        ce_pix_b, hblank_b, hsync_b, vblank_b, vsync_b, de_b, fs_b;
    logic [10:0] x_a, y_a, x_b, y_b;
    logic [7:0]  vr_a, vg_a, vb_a, vr_b, vg_b, vb_b;

    int total = 0;
    int bad = 0;
    int ce_cnt_a = 0;
    int ce_cnt_b = 0;

    // A: 40x12 raster, CE_DIV=2, active-low syncs. B: 24x7 raster, CE_DIV=1, active-high syncs.
    gl_vga_timing_gen #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CE_DIV(2), .CW(11)
    ) dut_a (
        .clk(clk), .reset(reset_a), .mode(mode_a), .ce_pix(ce_pix_a),
        .HBlank(hblank_a), .HSync(hsync_a), .VBlank(vblank_a), .VSync(vsync_a),
        .de(de_a), .x(x_a), .y(y_a), .frame_start(fs_a),
        .vr(vr_a), .vg(vg_a), .vb(vb_a)
    );

    gl_vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CE_DIV(1), .CW(11)
    ) dut_b (
        .clk(clk), .reset(reset_b), .mode(mode_b), .ce_pix(ce_pix_b),
        .HBlank(hblank_b), .HSync(hsync_b), .VBlank(vblank_b), .VSync(vsync_b),
        .de(de_b), .x(x_b), .y(y_b), .frame_start(fs_b),
        .vr(vr_b), .vg(vg_b), .vb(vb_b)
    );

    // Count pixel-enable edges; after k of them the outputs show raster position k-1.
    always @(posedge clk) begin
        if (reset_a) ce_cnt_a <= 0;
        else if (ce_pix_a) ce_cnt_a <= ce_cnt_a + 1;
        if (reset_b) ce_cnt_b <= 0;
        else if (ce_pix_b) ce_cnt_b <= ce_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bord(input int px, input int py, input int xmax,
                                         input int ymax, input logic [23:0] v);
`ifdef GLVGA_BORDER_EN
        if (px == 0 || px == xmax || py == 0 || py == ymax) return 24'hFF0000;
`endif
        return v;
    endfunction

    task automatic wait_a(input int k);
        int g = 0;
        while (ce_cnt_a < k && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (ce_cnt_a < k) check("wait_a_timeout", ce_cnt_a, k);
    endtask

    task automatic wait_b(input int k);
        int g = 0;
        while (ce_cnt_b < k && g < 60000) begin
            @(negedge clk);
            g++;
        end
        if (ce_cnt_b < k) check("wait_b_timeout", ce_cnt_b, k);
    endtask

    task automatic pix_a(input string tag, input int k, input logic [23:0] exp);
        wait_a(k);
        check(tag, {vr_a, vg_a, vb_a}, exp);
    endtask

    initial begin
        int n, g, hb, base;
        reset_a = 1'b1; reset_b = 1'b1; mode_a = 2'd0; mode_b = 2'd3;
        repeat (3) @(negedge clk);
        check("rst_ce_a", ce_pix_a, 0);
        check("rst_hblank_a", hblank_a, 1);
        check("rst_vblank_a", vblank_a, 1);
        check("rst_hsync_a", hsync_a, 1);
        check("rst_vsync_a", vsync_a, 1);
        check("rst_de_a", de_a, 0);
        check("rst_xy_a", {x_a, y_a}, 0);
        check("rst_fs_a", fs_a, 0);
        check("rst_rgb_a", {vr_a, vg_a, vb_a}, 0);
        check("rst_hsync_b", hsync_b, 0);
        check("rst_vsync_b", vsync_b, 0);
        check("rst_ce_b", ce_pix_b, 0);
        reset_a = 1'b0; reset_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ce_toggle_a", ce_pix_a, (i % 2 == 1));
            check("ce_const_b", ce_pix_b, 1);
        end

        wait_a(1);
        check("fs_first_a", fs_a, 1);
        check("de_origin_a", de_a, 1);
        check("xy_origin_a", {x_a, y_a}, 0);
        check("hblank_origin_a", hblank_a, 0);
        check("hsync_origin_a", hsync_a, 1);
        check("rgb_origin_a", {vr_a, vg_a, vb_a}, bord(0, 0, 31, 7, 24'h000000));
        wait_a(2);
        check("fs_pulse_a", fs_a, 0);
        check("x1_a", x_a, 1);
        pix_a("bar1_a", 6, bord(5, 0, 31, 7, 24'h0000FF));
        pix_a("bar4_a", 18, bord(17, 0, 31, 7, 24'hFF0000));
        check("x17_a", x_a, 17);
        pix_a("bar7_a", 31, bord(30, 0, 31, 7, 24'hFFFFFF));
        wait_a(33);
        check("hblank_fp_a", hblank_a, 1);
        check("de_fp_a", de_a, 0);
        check("x_blank_a", x_a, 0);
        check("rgb_blank_a", {vr_a, vg_a, vb_a}, 0);
        check("hsync_fp_a", hsync_a, 1);
        wait_a(35);
        check("hsync_start_a", hsync_a, 0);
        wait_a(37);
        check("hsync_end_a", hsync_a, 0);
        wait_a(38);
        check("hsync_bp_a", hsync_a, 1);
        check("hblank_bp_a", hblank_a, 1);
        wait_a(41);
        check("line1_y_a", y_a, 1);
        check("line1_x_a", x_a, 0);
        check("line1_de_a", de_a, 1);
        pix_a("bar1_row5_a", 205, bord(4, 5, 31, 7, 24'h0000FF));
        mode_a = 2'd3;
        pix_a("midframe_mode_a", 210, 24'h00FF00);
        wait_a(321);
        check("vblank_a", vblank_a, 1);
        check("vblank_de_a", de_a, 0);
        check("vblank_y_a", y_a, 0);
        wait_a(366);
        check("vsync_start_a", vsync_a, 0);
        wait_a(440);
        check("vsync_end_a", vsync_a, 0);
        wait_a(441);
        check("vsync_off_a", vsync_a, 1);
        check("vblank_bp_a", vblank_a, 1);
        wait_a(481);
        check("fs_frame1_a", fs_a, 1);
        check("vblank_frame1_a", vblank_a, 0);
        pix_a("grad_x0_a", 681, bord(0, 5, 31, 7, {8'd0, 8'd5, 8'd1}));
        pix_a("grad_a", 684, {8'd3, 8'd5, 8'd1});
        mode_a = 2'd1;
        pix_a("grid_blk_a", 1050, 24'h000000);
        pix_a("grid_x0_a", 1081, bord(0, 3, 31, 7, 24'hFFFFFF));
        pix_a("grid_blk2_a", 1084, 24'h000000);
        pix_a("grid_x8_a", 1089, 24'hFFFFFF);
        pix_a("grid_xlast_a", 1112, bord(31, 3, 31, 7, 24'hFFFFFF));
        pix_a("grid_ylast_a", 1250, bord(9, 7, 31, 7, 24'hFFFFFF));
        mode_a = 2'd2;
        pix_a("chk_blue_a", 1526, 24'h0000FF);
        pix_a("chk_white_a", 1541, 24'hFFFFFF);

        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        check("mrst_ce_a", ce_pix_a, 0);
        check("mrst_blank_a", {hblank_a, vblank_a}, 2'b11);
        check("mrst_sync_a", {hsync_a, vsync_a}, 2'b11);
        check("mrst_de_fs_a", {de_a, fs_a}, 0);
        check("mrst_xy_a", {x_a, y_a}, 0);
        check("mrst_rgb_a", {vr_a, vg_a, vb_a}, 0);
        reset_a = 1'b0;
        wait_a(1);
        check("mrst_fs_a", fs_a, 1);
        check("mrst_origin_a", {x_a, y_a}, 0);
        pix_a("mrst_chk_a", 6, bord(5, 0, 31, 7, 24'h0000FF));
        check("mrst_x5_a", x_a, 5);

        base = 30 * 168;
        wait_b(base + 1);
        check("fs_b", fs_b, 1);
        wait_b(base + 18);
        check("hsync_pre_b", hsync_b, 0);
        wait_b(base + 19);
        check("hsync_start_b", hsync_b, 1);
        wait_b(base + 21);
        check("hsync_end_b", hsync_b, 1);
        wait_b(base + 22);
        check("hsync_post_b", hsync_b, 0);
        wait_b(base + 30);
        check("grad_b", {vr_b, vg_b, vb_b}, {8'd5, 8'd1, 8'd30});
        check("vblank_act_b", vblank_b, 0);
        wait_b(base + 100);
        check("vsync_pre_b", vsync_b, 0);
        check("vblank_fp_b", vblank_b, 1);
        wait_b(base + 124);
        check("vsync_on_b", vsync_b, 1);
        wait_b(base + 148);
        check("vsync_post_b", vsync_b, 0);

        g = 0;
        while (!fs_b && g < 400) begin
            @(negedge clk);
            g++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_b && n < 400);
        check("fs_period_b", n, 168);
        hb = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (hblank_b) hb++;
        end
        check("hblank_count_b", hb, 8);

        wait_b(286 * 168 + 30);
        check("fcnt_wrap_b", {vr_b, vg_b, vb_b}, {8'd5, 8'd1, 8'd30});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gl_vga_timing_gen.md
Name: gl_vga_timing_gen

Overview:
- Parametrised successor to the fixed-resolution VGA pattern block.
- Generates a full timing raster with configurable porches, sync widths, sync polarity and pixel-enable divider.
- Provides pixel coordinates, data-enable and a frame-start strobe, plus a 4-mode test pattern generator with a per-frame animation counter.
- Sits between the core clock domain and the MiSTer video output path: it is the raster source, and the same coordinates will drive future framebuffer readers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, HSync active level (0 = active-low)
- VS_POL, 0, VSync active level (0 = active-low)
- CE_DIV, 2, clk cycles per pixel; legal values 1..16
- CW, 11, width of the coordinate counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  test pattern select; sampled at frame start only
- ce_pix  out  1  pixel clock enable
- HBlank  out  1  high outside the active columns
- HSync  out  1  horizontal sync at HS_POL level
- VBlank  out  1  high outside the active lines
- VSync  out  1  vertical sync at VS_POL level
- de  out  1  ~HBlank & ~VBlank
- x  out  CW  active column, 0..H_ACTIVE-1; 0 when blanked
- y  out  CW  active line, 0..V_ACTIVE-1; 0 when blanked
- frame_start  out  1  one-ce pulse at pixel (0,0)
- vr, vg, vb  out  8 each  pixel colour

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Pixel enable divider:
  - Counter cdiv runs 0..CE_DIV-1 and wraps.
  - ce_pix is registered and is high for one clk when cdiv == CE_DIV-1.
  - With CE_DIV = 1, ce_pix is held high every cycle after reset.
- Raster counters:
  - hc and vc advance only on cycles where ce_pix is high.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is built the same way.
  - Horizontal line order: active [0, H_ACTIVE), front porch, sync, back porch.
  - When hc reaches H_TOTAL-1 it wraps to 0 and vc increments. When vc reaches V_TOTAL-1 it wraps to 0.
- Outputs:
  - All outputs are registered and update only on ce_pix cycles.
  - Latency is exactly 1 pixel (one ce) behind the hc/vc state they decode.
  - Sync is active when hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VSync follows the same rule per line.
  - Sync, blank and de are fully independent; sync is never derived from blank.
- Mode handling:
  - mode is latched into mode_q on the ce where hc = 0 and vc = 0.
  - A mid-frame change to mode has no visible effect until the next frame.
- Frame counter:
  - fcnt is 8 bits, increments on the ce at hc = H_TOTAL-1, vc = V_TOTAL-1, and wraps 255 -> 0.
- Patterns (applied while de is high; outside de, vr/vg/vb = 0):
  - mode 0, colour bars: 8 bars, each H_ACTIVE/8 wide (integer division). Bar index b uses bits {b[2], b[1], b[0]} to set R, G, B to 0xFF or 0x00. Bar 0 is black, bar 7 is white.
  - mode 1, grid: white where x[2:0] == 0, y[2:0] == 0, x == H_ACTIVE-1 or y == V_ACTIVE-1; black elsewhere.
  - mode 2, checker: white when x[4]^y[4], otherwise 0x0000FF.
  - mode 3, gradient: vr = x[7:0], vg = y[7:0], vb = fcnt.
- Reset values:
  - hc, vc, cdiv, fcnt, mode_q, ce_pix, x, y, frame_start, vr, vg, vb = 0.
  - HBlank = VBlank = 1, de = 0.
  - HSync = ~HS_POL, VSync = ~VS_POL (inactive).
  - A reset mid-frame restarts the raster at (0,0) on the next cycle. The first frame_start after reset is emitted on the second ce.
- Boundary condition: at the line and frame wrap on the same ce, hc, vc and fcnt update together, and frame_start is asserted on the following ce.

Optional Feature:
- Macro: GLVGA_BORDER_EN.
- Defined: during de, any pixel with x = 0, x = H_ACTIVE-1, y = 0 or y = V_ACTIVE-1 is forced to 0xFF/0x00/0x00 (red), overriding every pattern mode.
- Not defined: no border logic is synthesised, and the pattern output is unmodified.

Test Plan:
- Defaults, reset released -> ce_pix toggles every 2 clk. HSync low for exactly 96 ce starting at hc = 656. VSync low for 2 lines starting at line 490. One frame = 800x525 ce = 840000 clk.
- CE_DIV = 1, H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3, V_ACTIVE = 4, V_FP = V_SYNC = V_BP = 1 -> ce_pix constant 1. HBlank high 8 of every 24 cycles. frame_start period = 168 cycles.
- HS_POL = 1, VS_POL = 1 -> sync pulses active-high at the same positions. Reset level of both is 0.
- mode 0 at 640 wide -> pixel x = 80..159 is 0x0000FF, x = 560..639 is 0xFFFFFF. Blanked pixels are 0.
- mode changed from 0 to 3 at line 100 -> current frame stays bars. Next frame gives vr = x[7:0], vb = fcnt. After 256 frames fcnt reads the same value again (wrap).
- reset asserted at hc = 300, vc = 200 -> next cycle hc = vc = 0 and all outputs hold reset values. With GLVGA_BORDER_EN defined, pixel (0,5) reads 0xFF0000 in every mode.
